// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, per-stage
// pipeline-register control pair and its three legal encodings.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1
  } state_t;

  typedef struct packed {
    logic we;
    logic flush;
  } stage_ctrl_t;

  // A register only clears when both we and flush are set; we=0 always holds.
  localparam stage_ctrl_t SC_RUN    = '{we: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t SC_HOLD   = '{we: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t SC_BUBBLE = '{we: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard indications from the datapath and the pipeline-register controls
// returned to it. master = datapath side, slave = hazard controller.
interface pipe_hazard_ctrl_if;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       ex_md_start;
  logic       ex_md_is_div;
  logic       ex_branch_taken;
  logic       mem_wait;

  logic       pc_we;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_we;
  logic       idex_flush;
  logic       exmem_we;
  logic       exmem_flush;
  logic       memwb_we;
  logic       memwb_flush;
  logic       md_busy;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
           ex_md_start, ex_md_is_div, ex_branch_taken, mem_wait,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
           exmem_we, exmem_flush, memwb_we, memwb_flush, md_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
           ex_md_start, ex_md_is_div, ex_branch_taken, mem_wait,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
           exmem_we, exmem_flush, memwb_we, memwb_flush, md_busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_md_cnt.sv
// Multiply/divide occupancy down-counter: load, saturating decrement and a
// terminal-count (zero) flag.
module md_occupancy_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: priority decode of mem wait, taken
// branch, mult/div occupancy and load-use into per-stage we/flush controls.
//
// state   | meaning
// RUN     | normal issue; hazards resolved by priority each cycle
// MD_BUSY | mult/div occupies EX; upstream held until counter hits zero
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] md_last;
  logic [CNT_W-1:0] cnt_load_val;
  logic             load_use;
  logic             pc_we;
  logic             md_busy;
  stage_ctrl_t      ifid;
  stage_ctrl_t      idex;
  stage_ctrl_t      exmem;
  stage_ctrl_t      memwb;

  assign md_last = hz.ex_md_is_div ? DIV_LAST : MUL_LAST;
  // The start cycle already spends one occupancy cycle, so register one less.
  assign cnt_load_val = md_last - CNT_W'(1);

  assign load_use = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                    ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
                     (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));

  md_occupancy_cnt #(.CNT_W(CNT_W)) u_md_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    pc_we     = 1'b1;
    md_busy   = 1'b0;
    ifid      = SC_RUN;
    idex      = SC_RUN;
    exmem     = SC_RUN;
    memwb     = SC_RUN;

    if (!rst) begin
      state_nxt = RUN;
      pc_we     = 1'b0;
      ifid      = SC_BUBBLE;
      idex      = SC_BUBBLE;
      exmem     = SC_BUBBLE;
      memwb     = SC_BUBBLE;
    end else begin
      unique case (state)
        RUN: begin
          if (hz.mem_wait) begin
            pc_we = 1'b0;
            ifid  = SC_HOLD;
            idex  = SC_HOLD;
            exmem = SC_HOLD;
            memwb = SC_BUBBLE;
          end else if (hz.ex_branch_taken) begin
            ifid = SC_BUBBLE;
            idex = SC_BUBBLE;
          end else if (hz.ex_md_start) begin
            // A single-cycle mult/div needs no occupancy; it just advances.
            if (md_last != '0) begin
              state_nxt = MD_BUSY;
              cnt_load  = 1'b1;
              pc_we     = 1'b0;
              md_busy   = 1'b1;
              ifid      = SC_HOLD;
              idex      = SC_HOLD;
              exmem     = SC_BUBBLE;
            end
          end else if (load_use) begin
            pc_we = 1'b0;
            ifid  = SC_HOLD;
            idex  = SC_BUBBLE;
          end
        end

        MD_BUSY: begin
          cnt_dec = !cnt_zero;
          if (hz.mem_wait) begin
            pc_we   = 1'b0;
            md_busy = 1'b1;
            ifid    = SC_HOLD;
            idex    = SC_HOLD;
            exmem   = SC_HOLD;
            memwb   = SC_BUBBLE;
          end else if (cnt_zero) begin
            state_nxt = RUN;
          end else begin
            pc_we   = 1'b0;
            md_busy = 1'b1;
            ifid    = SC_HOLD;
            idex    = SC_HOLD;
            exmem   = SC_BUBBLE;
          end
        end

        default: state_nxt = RUN;
      endcase
    end
  end

  assign hz.pc_we       = pc_we;
  assign hz.md_busy     = md_busy;
  assign hz.ifid_we     = ifid.we;
  assign hz.ifid_flush  = ifid.flush;
  assign hz.idex_we     = idex.we;
  assign hz.idex_flush  = idex.flush;
  assign hz.exmem_we    = exmem.we;
  assign hz.exmem_flush = exmem.flush;
  assign hz.memwb_we    = memwb.we;
  assign hz.memwb_flush = memwb.flush;

endmodule
